vx_issue_sched: RTL and testbench
=================================

VX_ISSUE_SCHED -- requirements
Module: vx_issue_sched

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of per-warp instruction slots (>=2).
REQ-002 SHALL have parameter NUM_REGS, default 64, architectural registers per slot; RW=$clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_EX, default 5, number of execution-unit types; EW=$clog2(NUM_EX).
REQ-004 SHALL have parameter NUM_THREADS, default 4, thread-mask width.
REQ-005 SHALL have parameter CTR_W, default 44, perf-counter width.
REQ-006 clk  in  1  clock, all state on posedge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 slot_valid  in  NUM_SLOTS  slot holds an instruction.
REQ-009 slot_ready  out  NUM_SLOTS  one-hot or zero; slot instruction issued this cycle.
REQ-010 slot_wb  in  NUM_SLOTS  instruction writes rd.
REQ-011 slot_rd / slot_rs1 / slot_rs2 / slot_rs3  in  NUM_SLOTS*RW each  register indices.
REQ-012 slot_ex_type  in  NUM_SLOTS*EW  target unit.
REQ-013 slot_tmask  in  NUM_SLOTS*NUM_THREADS  active threads.
REQ-014 ex_ready  in  NUM_EX  unit accepts an instruction this cycle.
REQ-015 issue_valid  out  1;  issue_slot  out  $clog2(NUM_SLOTS);  issue_ex_type  out  EW;  issue_tmask  out  NUM_THREADS.
REQ-016 wb_valid  in  1;  wb_slot  in  $clog2(NUM_SLOTS);  wb_rd  in  RW;  wb_eop  in  1  writeback end-of-packet.
REQ-017 perf_scb_stalls  out  CTR_W;  perf_ex_stalls  out  NUM_EX*CTR_W;  perf_active_threads  out  CTR_W;  perf_issued  out  CTR_W.

Function
REQ-018 Scoreboard SHALL hold pending[NUM_SLOTS][NUM_REGS], one bit per slot/register.
REQ-019 Slot s hazard-free SHALL mean pending bits for rs1, rs2, rs3 and (if wb) rd all clear, read from registered state only (no same-cycle writeback bypass).
REQ-020 Slot s eligible SHALL mean slot_valid[s] & hazard-free & ex_ready[slot_ex_type[s]].
REQ-021 Selection SHALL be round-robin among eligible slots, starting at rr_ptr, combinational, zero-cycle latency.
REQ-022 On a grant to slot g: slot_ready[g]=1, issue_valid=1, issue_* carry slot g fields; issue_valid implies the target unit consumes the same cycle.
REQ-023 On a grant, rr_ptr SHALL become (g+1) mod NUM_SLOTS next cycle; without a grant rr_ptr holds.
REQ-024 On a grant with slot_wb[g] and slot_rd[g]!=0, pending[g][rd] SHALL be set next cycle; rd==0 never marked pending.
REQ-025 wb_valid & wb_eop SHALL clear pending[wb_slot][wb_rd] next cycle; wb_valid without wb_eop SHALL not change state.
REQ-026 Same-cycle set and clear of different bits SHALL both take effect; same bit cannot coincide (REQ-019), and if it does, set wins.
REQ-027 With no eligible slot, issue_valid=0, slot_ready=0, outputs of issue_* SHALL be 0.
REQ-028 perf_scb_stalls SHALL increment once per cycle in which some slot is valid but no slot is hazard-free.
REQ-029 perf_ex_stalls[e] SHALL increment once per cycle in which some hazard-free valid slot targets unit e and ex_ready[e]=0 and no grant occurs.
REQ-030 perf_active_threads SHALL add popcount(issue_tmask) on each grant; perf_issued SHALL add 1 on each grant.
REQ-031 All counters SHALL wrap modulo 2^CTR_W.

Reset
REQ-032 On reset all pending bits, rr_ptr and all perf counters SHALL be 0; slot_ready=0 and issue_valid=0 during reset regardless of inputs.
REQ-033 Writebacks arriving during reset SHALL be ignored; reset mid-operation discards all outstanding hazards.

Structure
REQ-034 Parameter defaults, EW/RW derivations and the EX type encodings SHALL live in the shared core package.
REQ-035 Round-robin selection SHALL be one sub-module, vx_rr_arbiter (NUM_REQS, request vector, grant one-hot, grant index, advance on fire).
REQ-036 Scoreboard, popcount and counters SHALL stay inline.

Verification
REQ-037 Slot0 valid wb rd=5 ex=0, ex_ready all 1 -> grant slot0 cycle 0; slot0 next instr rs1=5 stalls, perf_scb_stalls +1 per cycle until wb slot0 rd=5 eop, eligible the cycle after.
REQ-038 All 4 slots eligible continuously, no wb hazards -> grants 0,1,2,3,0 on consecutive cycles; perf_issued=5.
REQ-039 Slot1 hazard-free ex=2, ex_ready[2]=0 for 3 cycles -> no grant, perf_ex_stalls[2]=3, then grant when ex_ready[2]=1.
REQ-040 Grants with tmask 4'b1011 then 4'b1111 -> perf_active_threads=7.
REQ-041 Grant slot2 wb rd=0 -> no pending set; following rs1=0 instruction issues next cycle.
REQ-042 Reset asserted with pending[3][9] set and wb for slot3 rd=9 concurrent -> after reset all pending 0, counters 0, slot3 rs1=9 issues first cycle after reset.

Source files
------------

// File: rtl/vx_issue_sched_pkg.sv
// Shared core definitions for the issue scheduler slice.
// Holds the parameter defaults, the index-width helper that derives RW, EW and
// the slot-index width, and the execution-unit type encodings.
package vx_issue_sched_pkg;

    localparam int DEF_NUM_SLOTS   = 4;
    localparam int DEF_NUM_REGS    = 64;
    localparam int DEF_NUM_EX      = 5;
    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_CTR_W       = 44;

    // Width needed to index n items; never below one bit so that a
    // single-entry dimension still yields a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        EX_ALU = 3'd0,
        EX_LSU = 3'd1,
        EX_CSR = 3'd2,
        EX_FPU = 3'd3,
        EX_GPU = 3'd4
    } ex_type_e;

endpackage

// File: rtl/vx_issue_sched_if.sv
// Issue-scheduler bus: per-slot instruction fields, execution-unit ready
// lines, the issued-instruction outputs and the writeback return path.
//   master : instruction buffer / execution side (drives slots, ex_ready, wb)
//   slave  : the scheduler (drives slot_ready and issue_*)
interface vx_issue_sched_if
    import vx_issue_sched_pkg::*;
#(
    parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int NUM_EX      = DEF_NUM_EX,
    parameter int NUM_THREADS = DEF_NUM_THREADS
);
    localparam int RW = idx_w(NUM_REGS);
    localparam int EW = idx_w(NUM_EX);
    localparam int SW = idx_w(NUM_SLOTS);

    logic [NUM_SLOTS-1:0]             slot_valid;
    logic [NUM_SLOTS-1:0]             slot_ready;
    logic [NUM_SLOTS-1:0]             slot_wb;
    logic [NUM_SLOTS*RW-1:0]          slot_rd;
    logic [NUM_SLOTS*RW-1:0]          slot_rs1;
    logic [NUM_SLOTS*RW-1:0]          slot_rs2;
    logic [NUM_SLOTS*RW-1:0]          slot_rs3;
    logic [NUM_SLOTS*EW-1:0]          slot_ex_type;
    logic [NUM_SLOTS*NUM_THREADS-1:0] slot_tmask;
    logic [NUM_EX-1:0]                ex_ready;

    logic                             issue_valid;
    logic [SW-1:0]                    issue_slot;
    logic [EW-1:0]                    issue_ex_type;
    logic [NUM_THREADS-1:0]           issue_tmask;

    logic                             wb_valid;
    logic [SW-1:0]                    wb_slot;
    logic [RW-1:0]                    wb_rd;
    logic                             wb_eop;

    modport master (
        output slot_valid, slot_wb, slot_rd, slot_rs1, slot_rs2, slot_rs3,
               slot_ex_type, slot_tmask, ex_ready,
               wb_valid, wb_slot, wb_rd, wb_eop,
        input  slot_ready, issue_valid, issue_slot, issue_ex_type, issue_tmask
    );

    modport slave (
        input  slot_valid, slot_wb, slot_rd, slot_rs1, slot_rs2, slot_rs3,
               slot_ex_type, slot_tmask, ex_ready,
               wb_valid, wb_slot, wb_rd, wb_eop,
        output slot_ready, issue_valid, issue_slot, issue_ex_type, issue_tmask
    );

endinterface

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter with zero-cycle grant.
//   clk, reset   : clock, synchronous active-high reset
//   requests     : request vector
//   fire         : grant consumed this cycle; advances the priority pointer
//   grant        : one-hot grant (zero when nothing is requested)
//   grant_index  : binary index of the granted requester
//   grant_valid  : some requester was granted
module vx_rr_arbiter
    import vx_issue_sched_pkg::*;
#(
    parameter int NUM_REQS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           requests,
    input  logic                          fire,
    output logic [NUM_REQS-1:0]           grant,
    output logic [idx_w(NUM_REQS)-1:0]    grant_index,
    output logic                          grant_valid
);
    localparam int IW = idx_w(NUM_REQS);

    logic [IW-1:0] rr_ptr;
    int unsigned   cand;

    // Scan from rr_ptr upward with wraparound; the first request found wins.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end
            if (!grant_valid && requests[cand[IW-1:0]]) begin
                grant_valid              = 1'b1;
                grant_index              = cand[IW-1:0];
                grant[cand[IW-1:0]]      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (fire && grant_valid) begin
            rr_ptr <= (int'(grant_index) == NUM_REQS - 1) ? '0 : grant_index + IW'(1);
        end
    end

endmodule

// File: rtl/vx_issue_sched.sv
// Per-warp issue scheduler: register scoreboard, round-robin slot selection
// and performance counters.
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : slot instruction fields, ex_ready, issue outputs,
//                         writeback clear path
//   perf_scb_stalls     : cycles with valid slots but none hazard-free
//   perf_ex_stalls      : per-unit cycles blocked only by that unit being busy
//   perf_active_threads : sum of active threads over all issued instructions
//   perf_issued         : number of issued instructions
module vx_issue_sched
    import vx_issue_sched_pkg::*;
#(
    parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int NUM_EX      = DEF_NUM_EX,
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int CTR_W       = DEF_CTR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_issue_sched_if.slave         bus,
    output logic [CTR_W-1:0]        perf_scb_stalls,
    output logic [NUM_EX*CTR_W-1:0] perf_ex_stalls,
    output logic [CTR_W-1:0]        perf_active_threads,
    output logic [CTR_W-1:0]        perf_issued
);
    localparam int RW = idx_w(NUM_REGS);
    localparam int EW = idx_w(NUM_EX);
    localparam int SW = idx_w(NUM_SLOTS);
    localparam int TW = $clog2(NUM_THREADS + 1);

    logic [NUM_REGS-1:0]    pending  [NUM_SLOTS];
    logic [NUM_REGS-1:0]    set_mask [NUM_SLOTS];
    logic [NUM_REGS-1:0]    clr_mask [NUM_SLOTS];

    logic [RW-1:0]          rd_f  [NUM_SLOTS];
    logic [RW-1:0]          rs1_f [NUM_SLOTS];
    logic [RW-1:0]          rs2_f [NUM_SLOTS];
    logic [RW-1:0]          rs3_f [NUM_SLOTS];
    logic [EW-1:0]          ex_f  [NUM_SLOTS];
    logic [NUM_THREADS-1:0] tm_f  [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]   hazard_free;
    logic [NUM_SLOTS-1:0]   eligible;
    logic [NUM_SLOTS-1:0]   requests;
    logic [NUM_SLOTS-1:0]   grant;
    logic [SW-1:0]          grant_idx;
    logic                   grant_valid;

    logic [EW-1:0]          issue_ex;
    logic [NUM_THREADS-1:0] issue_tm;
    logic [TW-1:0]          pop;
    logic                   scb_stall;
    logic [NUM_EX-1:0]      ex_stall;
    logic [CTR_W-1:0]       ex_ctr [NUM_EX];

    always_comb begin
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            rd_f[s]  = bus.slot_rd[s*RW +: RW];
            rs1_f[s] = bus.slot_rs1[s*RW +: RW];
            rs2_f[s] = bus.slot_rs2[s*RW +: RW];
            rs3_f[s] = bus.slot_rs3[s*RW +: RW];
            ex_f[s]  = bus.slot_ex_type[s*EW +: EW];
            tm_f[s]  = bus.slot_tmask[s*NUM_THREADS +: NUM_THREADS];
        end
    end

    // Hazard check reads only registered pending bits; a writeback landing
    // this cycle frees the register from the next cycle on.
    always_comb begin
        hazard_free = '0;
        eligible    = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            hazard_free[s] = !pending[s][rs1_f[s]] && !pending[s][rs2_f[s]]
                          && !pending[s][rs3_f[s]]
                          && !(bus.slot_wb[s] && pending[s][rd_f[s]]);
            eligible[s]    = bus.slot_valid[s] && hazard_free[s]
                          && (int'(ex_f[s]) < NUM_EX) && bus.ex_ready[ex_f[s]];
        end
        requests = reset ? '0 : eligible;
    end

    vx_rr_arbiter #(
        .NUM_REQS (NUM_SLOTS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .requests    (requests),
        .fire        (grant_valid),
        .grant       (grant),
        .grant_index (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        issue_ex = '0;
        issue_tm = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (grant[s]) begin
                issue_ex = issue_ex | ex_f[s];
                issue_tm = issue_tm | tm_f[s];
            end
        end
        bus.slot_ready    = grant;
        bus.issue_valid   = grant_valid;
        bus.issue_slot    = grant_idx;
        bus.issue_ex_type = issue_ex;
        bus.issue_tmask   = issue_tm;
    end

    always_comb begin
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            set_mask[s] = '0;
            clr_mask[s] = '0;
            if (grant[s] && bus.slot_wb[s] && (rd_f[s] != '0)) begin
                set_mask[s][rd_f[s]] = 1'b1;
            end
            if (bus.wb_valid && bus.wb_eop && (bus.wb_slot == SW'(s))) begin
                clr_mask[s][bus.wb_rd] = 1'b1;
            end
        end
    end

    // Set is applied after clear so a coinciding set/clear of one bit keeps it set.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (reset) begin
                pending[s] <= '0;
            end else begin
                pending[s] <= (pending[s] & ~clr_mask[s]) | set_mask[s];
            end
        end
    end

    always_comb begin
        scb_stall = (|bus.slot_valid) && !(|(bus.slot_valid & hazard_free));
        ex_stall  = '0;
        for (int unsigned e = 0; e < NUM_EX; e++) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                if (bus.slot_valid[s] && hazard_free[s] && (ex_f[s] == EW'(e))
                    && !bus.ex_ready[e] && !grant_valid) begin
                    ex_stall[e] = 1'b1;
                end
            end
        end
        pop = '0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            pop = pop + TW'(issue_tm[t]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_scb_stalls     <= '0;
            perf_active_threads <= '0;
            perf_issued         <= '0;
            for (int unsigned e = 0; e < NUM_EX; e++) begin
                ex_ctr[e] <= '0;
            end
        end else begin
            if (scb_stall) begin
                perf_scb_stalls <= perf_scb_stalls + CTR_W'(1);
            end
            for (int unsigned e = 0; e < NUM_EX; e++) begin
                if (ex_stall[e]) begin
                    ex_ctr[e] <= ex_ctr[e] + CTR_W'(1);
                end
            end
            if (grant_valid) begin
                perf_issued         <= perf_issued + CTR_W'(1);
                perf_active_threads <= perf_active_threads + CTR_W'(pop);
            end
        end
    end

    always_comb begin
        for (int unsigned e = 0; e < NUM_EX; e++) begin
            perf_ex_stalls[e*CTR_W +: CTR_W] = ex_ctr[e];
        end
    end

endmodule

// File: tb/tb_vx_issue_sched.sv
module tb_vx_issue_sched
    import vx_issue_sched_pkg::*;
;
    localparam int NS = 4;
    localparam int NR = 64;
    localparam int NE = 5;
    localparam int NT = 4;
    localparam int CW = 44;
    localparam int RW = 6;
    localparam int EW = 3;

    typedef struct {
        bit         v;
        int         slot;
        int         ex;
        logic [3:0] tm;
    } exp_t;

    logic clk;
    logic reset;
    logic [CW-1:0]    perf_scb_stalls;
    logic [NE*CW-1:0] perf_ex_stalls;
    logic [CW-1:0]    perf_active_threads;
    logic [CW-1:0]    perf_issued;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    vx_issue_sched_if #(
        .NUM_SLOTS   (NS),
        .NUM_REGS    (NR),
        .NUM_EX      (NE),
        .NUM_THREADS (NT)
    ) bus ();

    vx_issue_sched #(
        .NUM_SLOTS   (NS),
        .NUM_REGS    (NR),
        .NUM_EX      (NE),
        .NUM_THREADS (NT),
        .CTR_W       (CW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .perf_scb_stalls     (perf_scb_stalls),
        .perf_ex_stalls      (perf_ex_stalls),
        .perf_active_threads (perf_active_threads),
        .perf_issued         (perf_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_slot(input int s, input bit v, input bit wb, input int rd,
                            input int rs1, input int rs2, input int rs3,
                            input int ex, input logic [3:0] tm);
        bus.slot_valid[s]            = v;
        bus.slot_wb[s]               = wb;
        bus.slot_rd[s*RW +: RW]      = RW'(rd);
        bus.slot_rs1[s*RW +: RW]     = RW'(rs1);
        bus.slot_rs2[s*RW +: RW]     = RW'(rs2);
        bus.slot_rs3[s*RW +: RW]     = RW'(rs3);
        bus.slot_ex_type[s*EW +: EW] = EW'(ex);
        bus.slot_tmask[s*NT +: NT]   = tm;
    endtask

    task automatic clear_inputs();
        bus.slot_valid   = '0;
        bus.slot_wb      = '0;
        bus.slot_rd      = '0;
        bus.slot_rs1     = '0;
        bus.slot_rs2     = '0;
        bus.slot_rs3     = '0;
        bus.slot_ex_type = '0;
        bus.slot_tmask   = '0;
        bus.ex_ready     = '1;
        bus.wb_valid     = 1'b0;
        bus.wb_slot      = '0;
        bus.wb_rd        = '0;
        bus.wb_eop       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [3:0] er;
        reset = 1'b1;
        clear_inputs();
        for (int s = 0; s < NS; s++) set_slot(s, 1, 1, s + 1, 0, 0, 0, s, 4'b1111);
        bus.wb_valid = 1'b1;
        bus.wb_eop   = 1'b1;
        exp_q.push_back('{v:0, slot:0, ex:0, tm:4'b0000});
        @(posedge clk);
        @(negedge clk);
        e  = exp_q.pop_front();
        er = e.v ? 4'(1 << e.slot) : 4'b0000;
        n_tests++;
        if (bus.issue_valid !== e.v || bus.slot_ready !== er || bus.issue_slot !== 2'(e.slot)
            || bus.issue_ex_type !== 3'(e.ex) || bus.issue_tmask !== e.tm) begin
            n_fail++;
            $display("FAIL reset_grant: got v=%b rdy=%b slot=%0d ex=%0d tm=%b want v=%b rdy=%b",
                     bus.issue_valid, bus.slot_ready, bus.issue_slot, bus.issue_ex_type,
                     bus.issue_tmask, e.v, er);
        end
        n_tests++;
        if (perf_scb_stalls !== '0 || perf_issued !== '0 || perf_active_threads !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrs: got scb=%0d iss=%0d act=%0d want 0 0 0",
                     perf_scb_stalls, perf_issued, perf_active_threads);
        end
        n_tests++;
        if (perf_ex_stalls !== '0) begin
            n_fail++;
            $display("FAIL reset_ex_ctrs: got %h want 0", perf_ex_stalls);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
    endtask

    // Writeback hazard on slot0 rd=5, stall counting, eop-less wb ignored.
    task automatic test_raw_hazard();
        exp_t e;
        logic [3:0] er;
        int exp_scb = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            bus.wb_valid = 1'b0;
            bus.wb_eop   = 1'b0;
            bus.wb_slot  = 2'd0;
            bus.wb_rd    = 6'd5;
            case (c)
                0: begin
                    set_slot(0, 1, 1, 5, 0, 0, 0, 0, 4'b1011);
                    exp_q.push_back('{v:1, slot:0, ex:0, tm:4'b1011});
                end
                5: begin
                    set_slot(0, 1, 0, 0, 5, 0, 0, 0, 4'b1111);
                    exp_q.push_back('{v:1, slot:0, ex:0, tm:4'b1111});
                end
                default: begin
                    set_slot(0, 1, 0, 0, 5, 0, 0, 0, 4'b1111);
                    if (c == 2) bus.wb_valid = 1'b1;
                    if (c == 4) begin
                        bus.wb_valid = 1'b1;
                        bus.wb_eop   = 1'b1;
                    end
                    exp_q.push_back('{v:0, slot:0, ex:0, tm:4'b0000});
                end
            endcase
            @(negedge clk);
            e  = exp_q.pop_front();
            er = e.v ? 4'(1 << e.slot) : 4'b0000;
            n_tests++;
            if (bus.issue_valid !== e.v || bus.slot_ready !== er || bus.issue_slot !== 2'(e.slot)
                || bus.issue_ex_type !== 3'(e.ex) || bus.issue_tmask !== e.tm) begin
                n_fail++;
                $display("FAIL raw_grant c%0d: got v=%b rdy=%b slot=%0d ex=%0d tm=%b want v=%b rdy=%b slot=%0d ex=%0d tm=%b",
                         c, bus.issue_valid, bus.slot_ready, bus.issue_slot, bus.issue_ex_type,
                         bus.issue_tmask, e.v, er, e.slot, e.ex, e.tm);
            end
            n_tests++;
            if (perf_scb_stalls !== CW'(exp_scb)) begin
                n_fail++;
                $display("FAIL raw_scb c%0d: got %0d want %0d", c, perf_scb_stalls, exp_scb);
            end
            if (c >= 1 && c <= 4) exp_scb++;
            @(posedge clk);
            #1;
        end
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (perf_issued !== CW'(2) || perf_active_threads !== CW'(7) || perf_scb_stalls !== CW'(4)) begin
            n_fail++;
            $display("FAIL raw_ctrs: got iss=%0d act=%0d scb=%0d want 2 7 4",
                     perf_issued, perf_active_threads, perf_scb_stalls);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] er;
        do_reset();
        for (int s = 0; s < NS; s++) set_slot(s, 1, 0, 0, 0, 0, 0, s, 4'b1111);
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back('{v:1, slot:c % 4, ex:c % 4, tm:4'b1111});
            @(negedge clk);
            e  = exp_q.pop_front();
            er = e.v ? 4'(1 << e.slot) : 4'b0000;
            n_tests++;
            if (bus.issue_valid !== e.v || bus.slot_ready !== er || bus.issue_slot !== 2'(e.slot)
                || bus.issue_ex_type !== 3'(e.ex) || bus.issue_tmask !== e.tm) begin
                n_fail++;
                $display("FAIL rr_grant c%0d: got v=%b rdy=%b slot=%0d ex=%0d want slot=%0d ex=%0d",
                         c, bus.issue_valid, bus.slot_ready, bus.issue_slot, bus.issue_ex_type,
                         e.slot, e.ex);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (perf_issued !== CW'(5) || perf_active_threads !== CW'(20) || perf_scb_stalls !== '0) begin
            n_fail++;
            $display("FAIL rr_ctrs: got iss=%0d act=%0d scb=%0d want 5 20 0",
                     perf_issued, perf_active_threads, perf_scb_stalls);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ex_stall();
        exp_t e;
        logic [3:0] er;
        logic [NE*CW-1:0] exp_ex;
        do_reset();
        set_slot(1, 1, 0, 0, 0, 0, 0, int'(EX_CSR), 4'b0110);
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                bus.ex_ready = 5'b11011;
                exp_q.push_back('{v:0, slot:0, ex:0, tm:4'b0000});
            end else begin
                bus.ex_ready = 5'b11111;
                exp_q.push_back('{v:1, slot:1, ex:2, tm:4'b0110});
            end
            @(negedge clk);
            e  = exp_q.pop_front();
            er = e.v ? 4'(1 << e.slot) : 4'b0000;
            n_tests++;
            if (bus.issue_valid !== e.v || bus.slot_ready !== er || bus.issue_slot !== 2'(e.slot)
                || bus.issue_ex_type !== 3'(e.ex) || bus.issue_tmask !== e.tm) begin
                n_fail++;
                $display("FAIL ex_grant c%0d: got v=%b rdy=%b slot=%0d ex=%0d tm=%b want v=%b slot=%0d",
                         c, bus.issue_valid, bus.slot_ready, bus.issue_slot, bus.issue_ex_type,
                         bus.issue_tmask, e.v, e.slot);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
        exp_ex = '0;
        exp_ex[2*CW +: CW] = CW'(3);
        @(negedge clk);
        n_tests++;
        if (perf_ex_stalls !== exp_ex || perf_scb_stalls !== '0) begin
            n_fail++;
            $display("FAIL ex_ctrs: got ex=%h scb=%0d want ex=%h scb=0",
                     perf_ex_stalls, perf_scb_stalls, exp_ex);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rd_zero();
        exp_t e;
        logic [3:0] er;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) set_slot(2, 1, 1, 0, 0, 0, 0, 1, 4'b0001);
            else        set_slot(2, 1, 0, 0, 0, 0, 0, 1, 4'b0011);
            exp_q.push_back('{v:1, slot:2, ex:1, tm:(c == 0) ? 4'b0001 : 4'b0011});
            @(negedge clk);
            e  = exp_q.pop_front();
            er = e.v ? 4'(1 << e.slot) : 4'b0000;
            n_tests++;
            if (bus.issue_valid !== e.v || bus.slot_ready !== er || bus.issue_slot !== 2'(e.slot)
                || bus.issue_ex_type !== 3'(e.ex) || bus.issue_tmask !== e.tm) begin
                n_fail++;
                $display("FAIL rd0_grant c%0d: got v=%b rdy=%b slot=%0d ex=%0d tm=%b want v=%b slot=%0d",
                         c, bus.issue_valid, bus.slot_ready, bus.issue_slot, bus.issue_ex_type,
                         bus.issue_tmask, e.v, e.slot);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    // Same-cycle clear of slot0 rd3 and set of slot1 rd4; pending is per slot.
    task automatic test_set_clear();
        exp_t e;
        logic [3:0] er;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    set_slot(0, 1, 1, 3, 0, 0, 0, 0, 4'b1111);
                    exp_q.push_back('{v:1, slot:0, ex:0, tm:4'b1111});
                end
                1: begin
                    set_slot(1, 1, 1, 4, 0, 0, 0, 1, 4'b0101);
                    bus.wb_valid = 1'b1;
                    bus.wb_eop   = 1'b1;
                    bus.wb_slot  = 2'd0;
                    bus.wb_rd    = 6'd3;
                    exp_q.push_back('{v:1, slot:1, ex:1, tm:4'b0101});
                end
                2: begin
                    set_slot(0, 1, 0, 0, 3, 0, 0, 0, 4'b0001);
                    set_slot(1, 1, 0, 0, 4, 0, 0, 1, 4'b0010);
                    exp_q.push_back('{v:1, slot:0, ex:0, tm:4'b0001});
                end
                3: begin
                    set_slot(0, 1, 0, 0, 0, 4, 0, 0, 4'b1000);
                    set_slot(1, 1, 0, 0, 0, 0, 4, 1, 4'b0010);
                    exp_q.push_back('{v:1, slot:0, ex:0, tm:4'b1000});
                end
                default: begin
                    set_slot(1, 1, 0, 0, 4, 0, 0, 1, 4'b0010);
                    exp_q.push_back('{v:0, slot:0, ex:0, tm:4'b0000});
                end
            endcase
            @(negedge clk);
            e  = exp_q.pop_front();
            er = e.v ? 4'(1 << e.slot) : 4'b0000;
            n_tests++;
            if (bus.issue_valid !== e.v || bus.slot_ready !== er || bus.issue_slot !== 2'(e.slot)
                || bus.issue_ex_type !== 3'(e.ex) || bus.issue_tmask !== e.tm) begin
                n_fail++;
                $display("FAIL setclr_grant c%0d: got v=%b rdy=%b slot=%0d ex=%0d tm=%b want v=%b slot=%0d tm=%b",
                         c, bus.issue_valid, bus.slot_ready, bus.issue_slot, bus.issue_ex_type,
                         bus.issue_tmask, e.v, e.slot, e.tm);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (perf_scb_stalls !== CW'(1) || perf_issued !== CW'(4)) begin
            n_fail++;
            $display("FAIL setclr_ctrs: got scb=%0d iss=%0d want 1 4", perf_scb_stalls, perf_issued);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [3:0] er;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    set_slot(2, 1, 1, 7, 0, 0, 0, 0, 4'b0001);
                    exp_q.push_back('{v:1, slot:2, ex:0, tm:4'b0001});
                end
                1: begin
                    set_slot(3, 1, 1, 9, 0, 0, 0, 4, 4'b1000);
                    exp_q.push_back('{v:1, slot:3, ex:4, tm:4'b1000});
                end
                2, 3: begin
                    reset = 1'b1;
                    set_slot(0, 1, 0, 0, 0, 0, 0, 0, 4'b1111);
                    set_slot(2, 1, 0, 0, 7, 0, 0, 0, 4'b0001);
                    set_slot(3, 1, 0, 0, 9, 0, 0, 4, 4'b1000);
                    bus.wb_valid = 1'b1;
                    bus.wb_eop   = 1'b1;
                    bus.wb_slot  = 2'd3;
                    bus.wb_rd    = 6'd9;
                    exp_q.push_back('{v:0, slot:0, ex:0, tm:4'b0000});
                end
                4: begin
                    reset = 1'b0;
                    set_slot(3, 1, 0, 0, 9, 0, 0, 4, 4'b1000);
                    exp_q.push_back('{v:1, slot:3, ex:4, tm:4'b1000});
                end
                default: begin
                    set_slot(2, 1, 0, 0, 7, 0, 0, 0, 4'b0001);
                    exp_q.push_back('{v:1, slot:2, ex:0, tm:4'b0001});
                end
            endcase
            @(negedge clk);
            e  = exp_q.pop_front();
            er = e.v ? 4'(1 << e.slot) : 4'b0000;
            n_tests++;
            if (bus.issue_valid !== e.v || bus.slot_ready !== er || bus.issue_slot !== 2'(e.slot)
                || bus.issue_ex_type !== 3'(e.ex) || bus.issue_tmask !== e.tm) begin
                n_fail++;
                $display("FAIL rstmid_grant c%0d: got v=%b rdy=%b slot=%0d ex=%0d tm=%b want v=%b slot=%0d",
                         c, bus.issue_valid, bus.slot_ready, bus.issue_slot, bus.issue_ex_type,
                         bus.issue_tmask, e.v, e.slot);
            end
            if (c == 4) begin
                n_tests++;
                if (perf_issued !== '0 || perf_active_threads !== '0 || perf_scb_stalls !== '0) begin
                    n_fail++;
                    $display("FAIL rstmid_ctrs: got iss=%0d act=%0d scb=%0d want 0 0 0",
                             perf_issued, perf_active_threads, perf_scb_stalls);
                end
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_raw_hazard();
        test_back_to_back();
        test_ex_stall();
        test_rd_zero();
        test_set_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
